// File: rtl/pes_fpmul_pipe.sv
// rtl/pes_fpmul_pipe.sv - 3-stage pipelined {sign,exp,man} multiplier; define FPMUL_ROUND_EN for round-to-nearest-even, else truncate
module pes_fpmul_pipe #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W+MAN_W:0]   product,
  output logic                   done,
  input  logic                   out_ready,
  output logic                   ovf,
  output logic                   unf
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int MW   = MAN_W + 1;          // mantissa with hidden one
  localparam int PW   = 2 * MW;             // full product width
  localparam int EW   = EXP_W + 2;          // signed exponent working width
  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] E_OVF  = EW'(1 << EXP_W);

  // The whole pipe moves whenever the output slot is empty or being drained
  logic adv;
  assign adv      = !done | out_ready;
  assign in_ready = adv;

  logic [EXP_W-1:0] exp_a, exp_b;
  assign exp_a = a[W-2 -: EXP_W];
  assign exp_b = b[W-2 -: EXP_W];

  logic                 s1_v, s1_zero, s1_sign;
  logic signed [EW-1:0] s1_esum;
  logic [MW-1:0]        s1_ma, s1_mb;

  // S1: unpack, flush exp==0 operands to zero, sign and biased exponent sum
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
    end else if (adv) begin
      s1_v    <= in_valid;
      s1_zero <= (exp_a == '0) | (exp_b == '0);
      s1_sign <= a[W-1] ^ b[W-1];
      s1_esum <= $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_E;
      s1_ma   <= {1'b1, a[MAN_W-1:0]};
      s1_mb   <= {1'b1, b[MAN_W-1:0]};
    end
  end

  logic                 s2_v, s2_zero, s2_sign;
  logic signed [EW-1:0] s2_esum;
  logic [PW-1:0]        s2_prod;

  // S2: full-width mantissa multiply
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v <= 1'b0;
    end else if (adv) begin
      s2_v    <= s1_v;
      s2_zero <= s1_zero;
      s2_sign <= s1_sign;
      s2_esum <= s1_esum;
      s2_prod <= PW'(s1_ma) * PW'(s1_mb);
    end
  end

  logic                 n_shift;
  logic [PW-1:0]        norm;
  logic [MAN_W-1:0]     man_t;
  logic                 rnd;
  logic [MAN_W:0]       man_r;
  logic signed [EW-1:0] e_fin;
  logic                 unused_norm;

  // The product of two [1,2) mantissas is in [1,4): align so the leading one sits at PW-1
  always_comb begin
    n_shift = s2_prod[PW-1];
    norm    = n_shift ? s2_prod : (s2_prod << 1);
    man_t   = norm[PW-2 -: MAN_W];
`ifdef FPMUL_ROUND_EN
    // Guard is the first dropped bit; any lower bit set makes it strictly above the halfway point
    rnd     = norm[MAN_W] & ((|norm[MAN_W-1:0]) | man_t[0]);
`else
    rnd     = 1'b0;
`endif
    man_r   = {1'b0, man_t} + {{MAN_W{1'b0}}, rnd};
    // A carry out of the rounded mantissa means 1.111..+ulp = 10.000, so bump the exponent
    e_fin   = s2_esum + $signed({{(EW-1){1'b0}}, n_shift})
                      + $signed({{(EW-1){1'b0}}, man_r[MAN_W]});
  end

`ifdef FPMUL_ROUND_EN
  assign unused_norm = norm[PW-1];
`else
  assign unused_norm = ^{norm[PW-1], norm[MAN_W:0]};
`endif

  // S3: range-check and pack into the registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      done    <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else if (adv) begin
      done <= s2_v;
      if (s2_zero) begin
        product <= '0;
        ovf     <= 1'b0;
        unf     <= 1'b0;
      end else if (e_fin >= E_OVF) begin
        product <= {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
        ovf     <= 1'b1;
        unf     <= 1'b0;
      end else if (e_fin[EW-1] || (e_fin == '0)) begin
        product <= '0;
        ovf     <= 1'b0;
        unf     <= 1'b1;
      end else begin
        product <= {s2_sign, e_fin[EXP_W-1:0], man_r[MAN_W-1:0]};
        ovf     <= 1'b0;
        unf     <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pes_fpmul_pipe.md
PES_FPMUL_PIPE -- requirements
Module: pes_fpmul_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 6, meaning the exponent field width (legal range 3..10).
REQ-002 The block SHALL have parameter MAN_W, default 4, meaning the stored mantissa field width with an implicit leading 1 (legal range 2..23).
REQ-003 The block SHALL derive W = 1+EXP_W+MAN_W and BIAS = 2^(EXP_W-1)-1, giving 11 and 31 at the defaults, with operand layout {sign, exp, man}.
REQ-004 clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  a and b carry an operand pair.
REQ-007 in_ready  output  1  the block accepts a pair this cycle.
REQ-008 a, b  input  W  the operands.
REQ-009 product  output  W  the result.
REQ-010 done  output  1  product, ovf and unf are valid.
REQ-011 out_ready  input  1  the downstream consumer accepts the result.
REQ-012 ovf, unf  output  1 each  the overflow and underflow flags for the current result.

Function
REQ-013 The block SHALL be a 3-stage pipeline: S1 unpack, zero-detect, sign XOR and biased exponent sum; S2 (MAN_W+1)x(MAN_W+1) mantissa multiply; S3 normalise, round, range-check and pack.
REQ-014 The pipeline SHALL advance when adv = !done | out_ready, with in_ready = adv, and a pair SHALL be accepted when in_valid & in_ready.
REQ-015 Latency SHALL be 3 cycles from accept to done with no stall, and throughput SHALL be one result per cycle.
REQ-016 While done & !out_ready, every stage SHALL hold, and product, ovf, unf and done SHALL remain stable.
REQ-017 Bubbles SHALL propagate, so done SHALL be low for any slot that had no accept.
REQ-018 An operand whose exp field is 0 SHALL be treated as zero, with denormals flushed.
REQ-019 If either operand is zero, the result SHALL be all-zeros with ovf=0 and unf=0.
REQ-020 The result sign SHALL be sign_a XOR sign_b for all non-zero results.
REQ-021 The exponent SHALL be computed signed in EXP_W+2 bits as e = exp_a + exp_b - BIAS + n, where n=1 when product MSB (bit 2*MAN_W+1) is set, and the mantissa SHALL then be taken from the bits below the leading 1.
REQ-022 A rounding carry that overflows the mantissa SHALL renormalise, setting man=0 and incrementing e.
REQ-023 If the final e >= 2^EXP_W, product SHALL be {sign, all-ones, all-ones} with ovf=1.
REQ-024 If the final e <= 0, product SHALL be all-zeros with unf=1.
REQ-025 No infinity or NaN encodings SHALL exist, and exp all-ones SHALL be an ordinary finite exponent.

Reset
REQ-026 With rst high at a clock edge, all stage valids, done, ovf, unf and product SHALL clear to 0, and in_ready SHALL be 1 in the following cycle.
REQ-027 Reset mid-operation SHALL discard all in-flight results, with no done asserted for any pair accepted before reset.
REQ-028 Reset SHALL take priority over in_valid in the same cycle, and a pair presented in that cycle SHALL be dropped.

Configuration
REQ-029 The block SHALL use macro FPMUL_ROUND_EN.
REQ-030 With FPMUL_ROUND_EN defined, S3 SHALL apply round-to-nearest-even using the guard bit and the OR of all lower bits as sticky.
REQ-031 Without FPMUL_ROUND_EN, S3 SHALL truncate, so REQ-022 never fires.

Verification
REQ-032 Basic multiply: 0x1F8 x 0x1F8 (1.5 x 1.5) -> product 0x202 (2.25), done exactly 3 cycles after accept, ovf=0, unf=0.
REQ-033 Rounding mode: 0x1F9 x 0x1F1 (1.5625 x 1.0625) -> 0x1FB with FPMUL_ROUND_EN, 0x1FA without it.
REQ-034 Range handling: 0x3F0 x 0x3F0 -> 0x3FF with ovf=1; 0x7F0 x 0x3F0 -> 0x7FF with ovf=1; 0x010 x 0x010 -> 0x000 with unf=1.
REQ-035 Zero operand: 0x000 x 0x5F3 -> 0x000 with ovf=0 and unf=0; 0x00A (exp field 0) x 0x1F0 -> 0x000.
REQ-036 Back-to-back with stall: stream 6 pairs with in_valid held high and out_ready held low for 4 cycles mid-stream -> in_ready drops while done is stalled, no result is lost or duplicated, and results appear in order.
REQ-037 Reset mid-flight: accept 2 pairs, assert rst for 1 cycle before either completes -> done stays 0, and the next pair's result appears 3 cycles after its accept.
